// File: rtl/fifo_rd_stream_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_rd_stream_if                                                        |
// | Bundle of async_fifo read-port, output stream and flush signals.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  flush;
  logic                  flush_busy;
  logic                  flush_done;
  logic [CNT_WIDTH-1:0]  word_cnt;

  modport master (
    input  fifo_empty,
    output fifo_rd_en,
    input  fifo_rd_data,
    output out_valid,
    input  out_ready,
    output out_data,
    input  flush,
    output flush_busy,
    output flush_done,
    output word_cnt
  );

  modport slave (
    output fifo_empty,
    input  fifo_rd_en,
    output fifo_rd_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    output flush,
    input  flush_busy,
    input  flush_done,
    input  word_cnt
  );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_rd_stream                                                           |
// | async_fifo read-side consumer: 3-entry prefetch buffer, valid/ready out. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  fifo_rd_stream_if.master  bus
);

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    FLUSH  = 1'b1
  } state_t;

  localparam logic [1:0] LAST_SLOT = 2'd2;

  state_t                state;
  state_t                state_nxt;
  logic [1:0]            occ;
  logic                  infl;
  logic [1:0]            rd_ptr;
  logic [1:0]            wr_ptr;
  logic [DATA_WIDTH-1:0] mem [0:2];
  logic [CNT_WIDTH-1:0]  word_cnt;
  logic                  rd_en;
  logic                  flush_done;
  logic                  push;
  logic                  pop;
  logic                  flush_start;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST_SLOT) ? 2'd0 : p + 2'd1;
  endfunction

  // Issue bound counts the in-flight word so the buffer can never overflow.
  always_comb begin
    state_nxt  = state;
    rd_en      = 1'b0;
    flush_done = 1'b0;
    case (state)
      NORMAL: begin
        rd_en = ~bus.fifo_empty & (({1'b0, occ} + {2'b00, infl}) < 3'd3);
        if (bus.flush) state_nxt = FLUSH;
      end
      FLUSH: begin
        rd_en = ~bus.fifo_empty;
        if (bus.fifo_empty && !infl) begin
          state_nxt  = NORMAL;
          flush_done = 1'b1;
        end
      end
      default: state_nxt = NORMAL;
    endcase
  end

  assign flush_start = (state == NORMAL) && bus.flush;
  assign push        = infl && (state == NORMAL);
  assign pop         = (occ != 2'd0) && bus.out_ready;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state <= NORMAL;
      infl  <= 1'b0;
    end else begin
      state <= state_nxt;
      infl  <= bus.fifo_rd_en;
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      occ    <= 2'd0;
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
    end else if (flush_start) begin
      occ    <= 2'd0;
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage is reset so out_data reads zero straight out of reset.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      for (int i = 0; i < 3; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= bus.fifo_rd_data;
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst)   word_cnt <= '0;
    else if (pop) word_cnt <= word_cnt + 1'b1;
  end

  assign bus.fifo_rd_en = rd_en & ~rd_rst;
  assign bus.out_valid  = (occ != 2'd0);
  assign bus.out_data   = mem[rd_ptr];
  assign bus.flush_busy = (state == FLUSH);
  assign bus.flush_done = flush_done;
  assign bus.word_cnt   = word_cnt;

  a_no_read_when_empty: assert property (
    @(posedge rd_clk) disable iff (rd_rst) !(bus.fifo_rd_en && bus.fifo_empty));

  a_no_overflow: assert property (
    @(posedge rd_clk) disable iff (rd_rst) !(push && !pop && !flush_start && occ == 2'd3));

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fifo_rd_stream                                                        |
// | Directed bench for fifo_rd_stream with a behavioural async_fifo model.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_fifo_rd_stream;

  logic rd_clk = 1'b0;
  logic rd_rst;
  logic hold_empty;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [3:0] q[$];
  logic [3:0] got[$];
  int         got_cyc[$];
  int         cyc       = 0;
  int         rd_pulses = 0;
  int         bad_rd    = 0;
  int         done_cnt  = 0;

  fifo_rd_stream_if #(.DATA_WIDTH(4), .CNT_WIDTH(16)) bus ();

  fifo_rd_stream #(.DATA_WIDTH(4), .CNT_WIDTH(16)) dut (
    .rd_clk (rd_clk),
    .rd_rst (rd_rst),
    .bus    (bus)
  );

  initial forever #5 rd_clk = ~rd_clk;

  // FIFO model: read data appears one cycle after the strobe.
  always @(posedge rd_clk) begin
    if (bus.fifo_rd_en) begin
      rd_pulses++;
      if (q.size() == 0) bad_rd++;
      else bus.fifo_rd_data <= q.pop_front();
    end
  end

  always @(posedge rd_clk) begin
    cyc++;
    if (bus.out_valid && bus.out_ready) begin
      got.push_back(bus.out_data);
      got_cyc.push_back(cyc);
    end
    if (bus.flush_done) done_cnt++;
  end

  task automatic refresh();
    bus.fifo_empty = hold_empty || (q.size() == 0);
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
    refresh();
    #1;
  endtask

  task automatic push(input logic [3:0] v);
    q.push_back(v);
    refresh();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_checks++; if (bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", bus.fifo_rd_en); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== 4'd0) begin n_fail++; $display("FAIL reset_out_data: got %0d want 0", bus.out_data); end
    n_checks++; if (bus.flush_busy !== 1'b0) begin n_fail++; $display("FAIL reset_flush_busy: got %b want 0", bus.flush_busy); end
    n_checks++; if (bus.flush_done !== 1'b0) begin n_fail++; $display("FAIL reset_flush_done: got %b want 0", bus.flush_done); end
    n_checks++; if (bus.word_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_word_cnt: got %0d want 0", bus.word_cnt); end
    rd_rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_stream();
    logic [3:0] e [5];
    int base;
    e = '{4'd13, 4'd14, 4'd15, 4'd0, 4'd1};
    base = got.size();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(e[i]);
    for (int i = 0; i < 30 && (got.size() - base) < 5; i++) tick();
    n_checks++; if (got.size() - base != 5) begin n_fail++; $display("FAIL basic_count: got %0d want 5", got.size() - base); end
    for (int i = 0; i < 5 && base + i < got.size(); i++) begin
      n_checks++; if (got[base+i] !== e[i]) begin n_fail++; $display("FAIL basic_word%0d: got %0d want %0d", i, got[base+i], e[i]); end
      if (i > 0) begin
        n_checks++; if (got_cyc[base+i] != got_cyc[base+i-1] + 1) begin n_fail++; $display("FAIL basic_gap%0d: got cycle %0d want %0d", i, got_cyc[base+i], got_cyc[base+i-1] + 1); end
      end
    end
    repeat (2) tick();
    n_checks++; if (bus.word_cnt !== 16'd5) begin n_fail++; $display("FAIL basic_word_cnt: got %0d want 5", bus.word_cnt); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_valid: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    logic [3:0] e [8];
    int base, p0;
    e = '{4'd3, 4'd5, 4'd7, 4'd9, 4'd11, 4'd2, 4'd4, 4'd6};
    bus.out_ready = 1'b0;
    base = got.size();
    p0 = rd_pulses;
    for (int i = 0; i < 8; i++) push(e[i]);
    repeat (8) tick();
    n_checks++; if (rd_pulses - p0 != 3) begin n_fail++; $display("FAIL bp_rd_pulses: got %0d want 3", rd_pulses - p0); end
    n_checks++; if (bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL bp_rd_en: got %b want 0", bus.fifo_rd_en); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'd3) begin n_fail++; $display("FAIL bp_hold%0d: got valid %b data %0d want 1/3", k, bus.out_valid, bus.out_data); end
      tick();
    end
    n_checks++; if (rd_pulses - p0 != 3) begin n_fail++; $display("FAIL bp_rd_pulses_held: got %0d want 3", rd_pulses - p0); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 30 && (got.size() - base) < 8; i++) tick();
    n_checks++; if (got.size() - base != 8) begin n_fail++; $display("FAIL bp_count: got %0d want 8", got.size() - base); end
    for (int i = 0; i < 8 && base + i < got.size(); i++) begin
      n_checks++; if (got[base+i] !== e[i]) begin n_fail++; $display("FAIL bp_word%0d: got %0d want %0d", i, got[base+i], e[i]); end
      if (i > 0) begin
        n_checks++; if (got_cyc[base+i] != got_cyc[base+i-1] + 1) begin n_fail++; $display("FAIL bp_gap%0d: got cycle %0d want %0d", i, got_cyc[base+i], got_cyc[base+i-1] + 1); end
      end
    end
    repeat (2) tick();
    n_checks++; if (bus.word_cnt !== 16'd13) begin n_fail++; $display("FAIL bp_word_cnt: got %0d want 13", bus.word_cnt); end
  endtask

  task automatic test_sparse_empty();
    int base;
    base = got.size();
    bus.out_ready = 1'b1;
    hold_empty = 1'b1;
    for (int i = 0; i < 6; i++) push(4'(10 + i));
    for (int i = 0; i < 40; i++) begin
      hold_empty = (((i >> 1) & 1) == 0);
      tick();
      n_checks++; if (bus.fifo_empty && bus.fifo_rd_en) begin n_fail++; $display("FAIL sparse_rd_en_cycle%0d: got rd_en 1 with empty 1 want 0", i); end
    end
    hold_empty = 1'b0;
    refresh();
    for (int i = 0; i < 20 && (got.size() - base) < 6; i++) tick();
    n_checks++; if (got.size() - base != 6) begin n_fail++; $display("FAIL sparse_count: got %0d want 6", got.size() - base); end
    for (int i = 0; i < 6 && base + i < got.size(); i++) begin
      n_checks++; if (got[base+i] !== 4'(10 + i)) begin n_fail++; $display("FAIL sparse_word%0d: got %0d want %0d", i, got[base+i], 10 + i); end
    end
    repeat (2) tick();
    n_checks++; if (bus.word_cnt !== 16'd19) begin n_fail++; $display("FAIL sparse_word_cnt: got %0d want 19", bus.word_cnt); end
  endtask

  task automatic test_flush();
    int base, d0;
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push(4'(i));
    repeat (6) tick();
    n_checks++; if (q.size() != 3 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_setup: got fifo %0d valid %b want 3/1", q.size(), bus.out_valid); end
    base = got.size();
    d0 = done_cnt;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid_next: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.flush_busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_next: got %b want 1", bus.flush_busy); end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid_cycle%0d: got %b want 0", i, bus.out_valid); end
    end
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL flush_done_pulses: got %0d want 1", done_cnt - d0); end
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL flush_drained: got %0d left want 0", q.size()); end
    n_checks++; if (bus.flush_busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_end: got %b want 0", bus.flush_busy); end
    n_checks++; if (got.size() != base) begin n_fail++; $display("FAIL flush_handshakes: got %0d want 0", got.size() - base); end
    n_checks++; if (bus.word_cnt !== 16'd19) begin n_fail++; $display("FAIL flush_word_cnt: got %0d want 19", bus.word_cnt); end
  endtask

  task automatic test_simultaneous();
    int base, d0;
    base = got.size();
    bus.out_ready = 1'b0;
    push(4'd5);
    tick();
    push(4'd8);
    tick();
    bus.out_ready = 1'b1;
    tick();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'd8) begin n_fail++; $display("FAIL simul_advance: got valid %b data %0d want 1/8", bus.out_valid, bus.out_data); end
    n_checks++; if (got.size() - base != 1) begin n_fail++; $display("FAIL simul_first_pop: got %0d pops want 1", got.size() - base); end
    else begin
      n_checks++; if (got[base] !== 4'd5) begin n_fail++; $display("FAIL simul_first_word: got %0d want 5", got[base]); end
    end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL simul_occ_one: got valid %b want 0", bus.out_valid); end
    n_checks++; if (got.size() - base != 2) begin n_fail++; $display("FAIL simul_count: got %0d want 2", got.size() - base); end
    else begin
      n_checks++; if (got[base+1] !== 4'd8) begin n_fail++; $display("FAIL simul_second_word: got %0d want 8", got[base+1]); end
    end
    // Re-assert flush while still draining; only one done pulse may follow.
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push(4'(i));
    repeat (6) tick();
    d0 = done_cnt;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    tick();
    n_checks++; if (bus.flush_busy !== 1'b1) begin n_fail++; $display("FAIL reflush_busy: got %b want 1", bus.flush_busy); end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    repeat (20) tick();
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL reflush_done_pulses: got %0d want 1", done_cnt - d0); end
    n_checks++; if (bus.flush_busy !== 1'b0) begin n_fail++; $display("FAIL reflush_busy_end: got %b want 0", bus.flush_busy); end
    n_checks++; if (bus.word_cnt !== 16'd21) begin n_fail++; $display("FAIL reflush_word_cnt: got %0d want 21", bus.word_cnt); end
  endtask

  task automatic test_reset_mid();
    int base;
    base = got.size();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) push(4'(i));
    for (int i = 0; i < 30 && (got.size() - base) < 2; i++) tick();
    n_checks++; if (got.size() - base != 2) begin n_fail++; $display("FAIL rstmid_pre_count: got %0d want 2", got.size() - base); end
    rd_rst = 1'b1;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 4'd0) begin n_fail++; $display("FAIL rstmid_out: got valid %b data %0d want 0/0", bus.out_valid, bus.out_data); end
    n_checks++; if (bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_rd_en: got %b want 0", bus.fifo_rd_en); end
    n_checks++; if (bus.flush_busy !== 1'b0 || bus.flush_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_flush: got busy %b done %b want 0/0", bus.flush_busy, bus.flush_done); end
    n_checks++; if (bus.word_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_word_cnt: got %0d want 0", bus.word_cnt); end
    q.delete();
    tick();
    rd_rst = 1'b0;
    tick();
    base = got.size();
    push(4'd7);
    push(4'd9);
    for (int i = 0; i < 20 && (got.size() - base) < 2; i++) tick();
    n_checks++; if (got.size() - base != 2) begin n_fail++; $display("FAIL rstmid_reload_count: got %0d want 2", got.size() - base); end
    else begin
      n_checks++; if (got[base] !== 4'd7 || got[base+1] !== 4'd9) begin n_fail++; $display("FAIL rstmid_reload_words: got %0d,%0d want 7,9", got[base], got[base+1]); end
    end
    repeat (2) tick();
    n_checks++; if (bus.word_cnt !== 16'd2) begin n_fail++; $display("FAIL rstmid_reload_cnt: got %0d want 2", bus.word_cnt); end
  endtask

  initial begin
    rd_rst         = 1'b1;
    hold_empty     = 1'b0;
    bus.out_ready  = 1'b0;
    bus.flush      = 1'b0;
    bus.fifo_empty = 1'b1;
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_sparse_empty();
    test_flush();
    test_simultaneous();
    test_reset_mid();
    n_checks++; if (bad_rd != 0) begin n_fail++; $display("FAIL read_while_empty: got %0d strobes want 0", bad_rd); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
